usb_in_ep_buffer: RTL and testbench

USB_IN_EP_BUFFER -- requirements
Module: usb_in_ep_buffer

---
 rtl/usb_in_ep_buffer.sv | 182 ++++++++++++++++++
 tb/tb_usb_in_ep_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_ep_buffer.sv
// USB IN endpoint packet buffer.
// The client fills one packet, the transmit engine reads it out, and the buffer is
// retained until the host ACKs, so a retransmit resends the same bytes.
// Optional STALL handling is compiled in with macro USB_IN_EP_STALL_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FILL     | client owns the buffer and may write bytes
// READY    | packet complete, waiting for an IN token
// SEND     | bytes streamed to the transmit engine
// WAIT_ACK | packet sent, waiting for host ACK or a retransmit IN token
// STALL    | endpoint halted until SETUP (only with USB_IN_EP_STALL_EN)
module usb_in_ep_buffer #(
    parameter int MAX_PKT_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       setup_token,
    input  logic       in_xfr_start,
    input  logic       in_xfr_ack,
    output logic       tx_pkt_ready,
    output logic       tx_stall,
    output logic       tx_data_toggle,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data
);

    localparam int CW = $clog2(MAX_PKT_SIZE + 1);
    localparam int AW = $clog2(MAX_PKT_SIZE);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_SIZE);

`ifdef USB_IN_EP_STALL_EN
    typedef enum logic [2:0] {S_FILL, S_READY, S_SEND, S_WAIT_ACK, S_STALL} state_t;
`else
    typedef enum logic [2:0] {S_FILL, S_READY, S_SEND, S_WAIT_ACK} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            toggle_q, toggle_d;
    logic            grant_q;
    logic            acked_q, acked_d;
    logic            wr_en;
    logic [7:0]      mem_q [MAX_PKT_SIZE];

`ifdef USB_IN_EP_STALL_EN
    logic            stall_q, stall_d;
`else
    logic            unused_stall;
    assign unused_stall = in_ep_stall;
`endif

    assign in_ep_grant     = grant_q;
    assign in_ep_acked     = acked_q;
    assign tx_data_toggle  = toggle_q;
    assign in_ep_data_free = (state_q == S_FILL) && grant_q && (count_q < MAX_CNT);
    assign tx_pkt_ready    = (state_q == S_READY);
    assign tx_data_avail   = (state_q == S_SEND) && (rd_ptr_q < count_q);
    // rd_ptr < count <= MAX_PKT_SIZE whenever avail is high, so the index is in range
    assign tx_data         = tx_data_avail ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

`ifdef USB_IN_EP_STALL_EN
    assign tx_stall = stall_q;
`else
    assign tx_stall = 1'b0;
`endif

    // Next-state logic: SETUP beats STALL, STALL beats every per-state event
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        toggle_d = toggle_q;
        acked_d  = 1'b0;
        wr_en    = 1'b0;
`ifdef USB_IN_EP_STALL_EN
        stall_d  = stall_q;
`endif
        if (setup_token) begin
            state_d  = S_FILL;
            count_d  = '0;
            rd_ptr_d = '0;
            toggle_d = 1'b1;
`ifdef USB_IN_EP_STALL_EN
            stall_d  = 1'b0;
        end else if (in_ep_stall) begin
            state_d  = S_STALL;
            count_d  = '0;
            rd_ptr_d = '0;
            stall_d  = 1'b1;
`endif
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_ep_data_put && in_ep_data_free) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                    if (in_ep_data_done || (count_d == MAX_CNT)) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (in_xfr_start) begin
                        rd_ptr_d = '0;
                        state_d  = S_SEND;
                    end
                end
                S_SEND: begin
                    // Compare on the registered pointer so an empty packet leaves after one cycle
                    if (rd_ptr_q == count_q) begin
                        state_d = S_WAIT_ACK;
                    end else if (tx_data_get) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (in_xfr_ack) begin
                        acked_d  = 1'b1;
                        toggle_d = ~toggle_q;
                        count_d  = '0;
                        state_d  = S_FILL;
                    end else if (in_xfr_start) begin
                        rd_ptr_d = '0;
                        state_d  = S_SEND;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FILL;
            count_q  <= '0;
            rd_ptr_q <= '0;
            toggle_q <= 1'b0;
            grant_q  <= 1'b0;
            acked_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            toggle_q <= toggle_d;
            grant_q  <= in_ep_req;
            acked_q  <= acked_d;
        end
    end

`ifdef USB_IN_EP_STALL_EN
    // Stall flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    // Packet storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= in_ep_data;
        end
    end

endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Scoreboard bench for usb_in_ep_buffer: tasks drive stimulus and push expected
// bytes / ACK toggles into queues, a negedge monitor pops and compares them.
module tb_usb_in_ep_buffer;

    localparam int MAX = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ep_req, in_ep_data_put, in_ep_data_done, in_ep_stall;
    logic [7:0] in_ep_data;
    logic       setup_token, in_xfr_start, in_xfr_ack, tx_data_get;
    logic       in_ep_grant, in_ep_data_free, in_ep_acked;
    logic       tx_pkt_ready, tx_stall, tx_data_toggle, tx_data_avail;
    logic [7:0] tx_data;

    usb_in_ep_buffer #(.MAX_PKT_SIZE(MAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_ep_req      (in_ep_req),
        .in_ep_grant    (in_ep_grant),
        .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put (in_ep_data_put),
        .in_ep_data     (in_ep_data),
        .in_ep_data_done(in_ep_data_done),
        .in_ep_stall    (in_ep_stall),
        .in_ep_acked    (in_ep_acked),
        .setup_token    (setup_token),
        .in_xfr_start   (in_xfr_start),
        .in_xfr_ack     (in_xfr_ack),
        .tx_pkt_ready   (tx_pkt_ready),
        .tx_stall       (tx_stall),
        .tx_data_toggle (tx_data_toggle),
        .tx_data_avail  (tx_data_avail),
        .tx_data_get    (tx_data_get),
        .tx_data        (tx_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet contents and endpoint phase at transaction level
    typedef enum {P_FILL, P_READY, P_SENT, P_STALL} phase_t;
    phase_t        ph;
    byte unsigned  pkt[$];
    byte unsigned  exp_tx[$];
    bit            ack_q[$];
    bit            mtog;
    bit            req_m;
    byte unsigned  mon_e;
    bit            mon_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every consumed byte and every ACK pulse must match the queues
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (tx_data_avail === 1'b1 && tx_data_get === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got byte %0h expected none", tx_data);
                end else begin
                    mon_e = exp_tx.pop_front();
                    chk("tx_data", {24'h0, tx_data}, {24'h0, mon_e});
                end
            end
            if (in_ep_acked === 1'b1) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acked_extra: got pulse expected none");
                end else begin
                    mon_t = ack_q.pop_front();
                    chk("ack_toggle", {31'h0, tx_data_toggle}, {31'h0, mon_t});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ph   = P_FILL;
        mtog = 1'b0;
        pkt.delete();
        exp_tx.delete();
        ack_q.delete();
    endtask

    task automatic put_byte(input byte unsigned b);
        bit ok;
        ok = (ph == P_FILL) && req_m && (pkt.size() < MAX);
        chk("data_free", {31'h0, in_ep_data_free}, {31'h0, ok});
        in_ep_data_put = 1'b1;
        in_ep_data     = b;
        if (ok) begin
            pkt.push_back(b);
            if (pkt.size() == MAX) ph = P_READY;
        end
        tick();
        in_ep_data_put = 1'b0;
    endtask

    task automatic done_pkt();
        in_ep_data_done = 1'b1;
        if (ph == P_FILL) ph = P_READY;
        tick();
        in_ep_data_done = 1'b0;
        chk("pkt_ready", {31'h0, tx_pkt_ready}, {31'h0, (ph == P_READY)});
    endtask

    task automatic start_xfr();
        in_xfr_start = 1'b1;
        if (ph == P_READY || ph == P_SENT) begin
            exp_tx = pkt;
            ph     = P_SENT;
        end
        tick();
        in_xfr_start = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 4 * MAX + 20;
        while (exp_tx.size() > 0 && budget > 0) begin
            tx_data_get = 1'($urandom_range(0, 1));
            tick();
            budget--;
        end
        chk("drain_left", exp_tx.size(), 0);
        exp_tx.delete();
        tx_data_get = 1'b1;
        tick();
        tick();
        tx_data_get = 1'b0;
        chk("avail_after", {31'h0, tx_data_avail}, 32'h0);
        chk("ready_after", {31'h0, tx_pkt_ready}, 32'h0);
    endtask

    task automatic ack_xfr();
        in_xfr_ack = 1'b1;
        if (ph == P_SENT) begin
            mtog = ~mtog;
            ack_q.push_back(mtog);
            pkt.delete();
            ph = P_FILL;
        end
        tick();
        in_xfr_ack = 1'b0;
        tick();
        chk("ack_seen", ack_q.size(), 0);
        chk("toggle", {31'h0, tx_data_toggle}, {31'h0, mtog});
    endtask

    task automatic setup();
        setup_token = 1'b1;
        ph   = P_FILL;
        mtog = 1'b1;
        pkt.delete();
        tick();
        setup_token = 1'b0;
        chk("setup_toggle", {31'h0, tx_data_toggle}, 32'h1);
        chk("setup_stall", {31'h0, tx_stall}, 32'h0);
        chk("setup_free", {31'h0, in_ep_data_free}, {31'h0, req_m});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_grant"}, {31'h0, in_ep_grant}, 32'h0);
        chk({nm, "_acked"}, {31'h0, in_ep_acked}, 32'h0);
        chk({nm, "_ready"}, {31'h0, tx_pkt_ready}, 32'h0);
        chk({nm, "_stall"}, {31'h0, tx_stall}, 32'h0);
        chk({nm, "_avail"}, {31'h0, tx_data_avail}, 32'h0);
        chk({nm, "_toggle"}, {31'h0, tx_data_toggle}, 32'h0);
        chk({nm, "_data"}, {24'h0, tx_data}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        in_ep_req = 1'b0; in_ep_data_put = 1'b0; in_ep_data_done = 1'b0;
        in_ep_stall = 1'b0; in_ep_data = 8'h00; setup_token = 1'b0;
        in_xfr_start = 1'b0; in_xfr_ack = 1'b0; tx_data_get = 1'b0;
        req_m = 1'b0;
        model_reset();
        tick(); tick(); tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();

        // Client request and registered grant
        in_ep_req = 1'b1;
        chk("grant_lag", {31'h0, in_ep_grant}, 32'h0);
        tick();
        req_m = 1'b1;
        chk("grant", {31'h0, in_ep_grant}, 32'h1);

        // Basic three-byte packet
        put_byte(8'h12); put_byte(8'h01); put_byte(8'h00);
        done_pkt();
        start_xfr();
        drain();
        ack_xfr();

        // Full packet auto-completes; the next put is ignored
        for (int i = 0; i < MAX; i++) begin
            if (i == MAX - 1) chk("ready_early", {31'h0, tx_pkt_ready}, 32'h0);
            put_byte(8'(i * 7 + 3));
        end
        chk("full_ready", {31'h0, tx_pkt_ready}, 32'h1);
        put_byte(8'hEE);
        chk("full_free", {31'h0, in_ep_data_free}, 32'h0);
        start_xfr();
        drain();
        ack_xfr();

        // Zero-length packet
        done_pkt();
        start_xfr();
        drain();
        ack_xfr();

        // Retransmit without ACK keeps toggle
        for (int i = 0; i < 7; i++) put_byte(8'($urandom_range(0, 255)));
        done_pkt();
        start_xfr();
        drain();
        start_xfr();
        chk("retx_toggle", {31'h0, tx_data_toggle}, {31'h0, mtog});
        drain();
        ack_xfr();

        // Stall while a packet waits in READY
        put_byte(8'h5A); put_byte(8'hA5); put_byte(8'h3C);
        done_pkt();
        in_ep_stall = 1'b1;
        tick();
        in_ep_stall = 1'b0;
`ifdef USB_IN_EP_STALL_EN
        ph = P_STALL;
        pkt.delete();
        chk("stall_on", {31'h0, tx_stall}, 32'h1);
        chk("stall_ready", {31'h0, tx_pkt_ready}, 32'h0);
        put_byte(8'hAA);
        start_xfr();
        tx_data_get = 1'b1;
        tick();
        tx_data_get = 1'b0;
        chk("stall_avail", {31'h0, tx_data_avail}, 32'h0);
        chk("stall_hold", {31'h0, tx_stall}, 32'h1);
`else
        chk("nostall_off", {31'h0, tx_stall}, 32'h0);
        chk("nostall_ready", {31'h0, tx_pkt_ready}, 32'h1);
`endif
        setup();

        // Randomized packets with occasional retransmits
        for (int p = 0; p < 15; p++) begin
            int len;
            len = $urandom_range(0, MAX);
            for (int i = 0; i < len; i++) put_byte(8'($urandom_range(0, 255)));
            if (len < MAX) done_pkt();
            else chk("rnd_full_ready", {31'h0, tx_pkt_ready}, 32'h1);
            start_xfr();
            drain();
            if ($urandom_range(0, 3) == 0) begin
                start_xfr();
                drain();
            end
            ack_xfr();
        end

        // Reset in the middle of a transmit
        for (int i = 0; i < 5; i++) put_byte(8'(8'h40 + i));
        done_pkt();
        start_xfr();
        tx_data_get = 1'b1;
        tick();
        tick();
        chk("mid_popped", exp_tx.size(), 3);
        tx_data_get = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        model_reset();
        chk_idle("midrst");
        chk("midrst_free", {31'h0, in_ep_data_free}, 32'h0);
        in_ep_req = 1'b0;
        req_m = 1'b0;
        reset = 1'b0;
        tick(); tick(); tick();
        chk_idle("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
